// File: rtl/lc3_pkg.sv
// lc3_pkg -- shared definitions for the LC-3 control unit.
//
// Contents:
//   state_t      controller states, encoded with the Patt state numbers
//   OP_*         instruction opcodes (IR[15:12])
//   *_SEL / ALU_* datapath mux-select and ALU function encodings
//   ctrl_t       bundle of every Moore control output of the FSM
//   cc_from_bus  condition-code evaluation of a bus value
package lc3_pkg;

  localparam int LC3_WIDTH = 16;

  typedef enum logic [5:0] {
    S_BR        = 6'd0,
    S_ADD       = 6'd1,
    S_LD        = 6'd2,
    S_ST        = 6'd3,
    S_JSR       = 6'd4,
    S_AND       = 6'd5,
    S_LDR       = 6'd6,
    S_STR       = 6'd7,
    S_NOT       = 6'd9,
    S_LDI       = 6'd10,
    S_STI       = 6'd11,
    S_JMP       = 6'd12,
    S_LEA       = 6'd14,
    S_TRAP      = 6'd15,
    S_WRITE     = 6'd16,
    S_FETCH     = 6'd18,
    S_JSRR      = 6'd20,
    S_JSR_OFF   = 6'd21,
    S_BR_TAKEN  = 6'd22,
    S_ST_MDR    = 6'd23,
    S_LDI_RD    = 6'd24,
    S_LD_RD     = 6'd25,
    S_LDI_MAR   = 6'd26,
    S_LD_WB     = 6'd27,
    S_TRAP_RD   = 6'd28,
    S_STI_RD    = 6'd29,
    S_TRAP_PC   = 6'd30,
    S_STI_MAR   = 6'd31,
    S_DECODE    = 6'd32,
    S_FETCH_RD  = 6'd33,
    S_FETCH_IR  = 6'd35
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic       MARMUX_ZEXT  = 1'b0;
  localparam logic       MARMUX_ADDER = 1'b1;

  localparam logic       ADDR1_PC  = 1'b0;
  localparam logic       ADDR1_SR1 = 1'b1;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] SR1_IR11_9 = 2'b00;
  localparam logic [1:0] SR1_IR8_6  = 2'b01;
  localparam logic [1:0] SR1_R6     = 2'b10;

  localparam logic [1:0] DR_IR11_9 = 2'b00;
  localparam logic [1:0] DR_R7     = 2'b01;
  localparam logic [1:0] DR_R6     = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_NOT   = 2'b10;
  localparam logic [1:0] ALU_PASSA = 2'b11;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_pc;
    logic       ld_reg;
    logic       ld_ben;
    logic       ld_cc;
    logic       gate_marmux;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_pc;
    logic       marmux_sel;
    logic       addr1_sel;
    logic [1:0] addr2_sel;
    logic [1:0] pcmux_sel;
    logic [1:0] sr1_sel;
    logic [1:0] dr_sel;
    logic       cs;
    logic       we;
    logic [1:0] aluk;
  } ctrl_t;

  // Returns {N, Z, P} for a value seen on the bus; exactly one bit is set.
  function automatic logic [2:0] cc_from_bus(input logic [LC3_WIDTH-1:0] bus);
    logic neg;
    logic zero;
    neg  = bus[LC3_WIDTH-1];
    zero = (bus == '0);
    return {neg, zero, !neg && !zero};
  endfunction

endpackage

// File: rtl/lc3_nzp_ben.sv
// lc3_nzp_ben -- condition-code and branch-enable registers.
//
// Ports:
//   clk, rst   clock (rising edge) and asynchronous active-high reset
//   bus        datapath bus value evaluated when ld_cc is asserted
//   ir_cond    IR[11:9], the n/z/p mask of a BR instruction
//   ld_cc      load N/Z/P from bus
//   ld_ben     load BEN from ir_cond and the current N/Z/P
//   n, z, p    condition codes (reset to Z only)
//   ben        latched branch enable
module lc3_nzp_ben
  import lc3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus,
  input  logic [2:0]       ir_cond,
  input  logic             ld_cc,
  input  logic             ld_ben,
  output logic             n,
  output logic             z,
  output logic             p,
  output logic             ben
);

  // BEN is computed from the N/Z/P held before this edge, which the
  // non-blocking update gives us for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n   <= 1'b0;
      z   <= 1'b1;
      p   <= 1'b0;
      ben <= 1'b0;
    end else begin
      if (ld_cc) begin
        {n, z, p} <= cc_from_bus(bus);
      end
      if (ld_ben) begin
        ben <= |(ir_cond & {n, z, p});
      end
    end
  end

endmodule

// File: rtl/lc3_fsm.sv
// lc3_fsm -- LC-3 control unit: Moore state machine plus NZP/BEN registers.
//
// Ports:
//   CLK, RESET      clock (rising edge), asynchronous active-high reset
//   READY           memory access complete
//   BUS, IR         shared bus value and current instruction
//   N, Z, P, BEN    condition codes and latched branch enable
//   LD_*            register load enables
//   Gate*           bus driver enables
//   *MUXsel, ALUK   datapath selects (encodings in lc3_pkg)
//   CS, WE          memory enable and write
//
// Configuration: define LC3_TRAP_EN to execute TRAP (states 15/28/30);
// otherwise TRAP is treated like the unused opcodes and returns to fetch.
// Only WIDTH = 16 is supported.
module lc3_fsm
  import lc3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             READY,
  input  logic [WIDTH-1:0] BUS,
  input  logic [WIDTH-1:0] IR,
  output logic             N,
  output logic             Z,
  output logic             P,
  output logic             BEN,
  output logic             LD_MAR,
  output logic             LD_MDR,
  output logic             LD_IR,
  output logic             LD_PC,
  output logic             LD_REG,
  output logic             LD_BEN,
  output logic             LD_CC,
  output logic             GateMARMUX,
  output logic             GateMDR,
  output logic             GateALU,
  output logic             GatePC,
  output logic             MARMUXsel,
  output logic             ADDR1MUXsel,
  output logic [1:0]       ADDR2MUXsel,
  output logic [1:0]       PCMUXsel,
  output logic [1:0]       SR1MUXsel,
  output logic [1:0]       DRMUXsel,
  output logic             CS,
  output logic             WE,
  output logic [1:0]       ALUK
);

  state_t     state;
  state_t     state_next;
  ctrl_t      ctrl;
  logic [3:0] opcode;
  logic       ir_unused;

  assign opcode    = IR[15:12];
  assign ir_unused = ^IR[8:0];

  // State register; reset drops any memory access in progress and
  // restarts at fetch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; memory states stall until READY.
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = S_FETCH_RD;
      S_FETCH_RD: state_next = READY ? S_FETCH_IR : S_FETCH_RD;
      S_FETCH_IR: state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_BR:   state_next = S_BR;
          OP_ADD:  state_next = S_ADD;
          OP_LD:   state_next = S_LD;
          OP_ST:   state_next = S_ST;
          OP_JSR:  state_next = S_JSR;
          OP_AND:  state_next = S_AND;
          OP_LDR:  state_next = S_LDR;
          OP_STR:  state_next = S_STR;
          OP_NOT:  state_next = S_NOT;
          OP_LDI:  state_next = S_LDI;
          OP_STI:  state_next = S_STI;
          OP_JMP:  state_next = S_JMP;
          OP_LEA:  state_next = S_LEA;
`ifdef LC3_TRAP_EN
          OP_TRAP: state_next = S_TRAP;
`endif
          default: state_next = S_FETCH;
        endcase
      end
      S_BR:       state_next = BEN ? S_BR_TAKEN : S_FETCH;
      S_JSR:      state_next = IR[11] ? S_JSR_OFF : S_JSRR;
      S_LD:       state_next = S_LD_RD;
      S_LDR:      state_next = S_LD_RD;
      S_LD_RD:    state_next = READY ? S_LD_WB : S_LD_RD;
      S_LDI:      state_next = S_LDI_RD;
      S_LDI_RD:   state_next = READY ? S_LDI_MAR : S_LDI_RD;
      S_LDI_MAR:  state_next = S_LD_RD;
      S_ST:       state_next = S_ST_MDR;
      S_STR:      state_next = S_ST_MDR;
      S_STI:      state_next = S_STI_RD;
      S_STI_RD:   state_next = READY ? S_STI_MAR : S_STI_RD;
      S_STI_MAR:  state_next = S_ST_MDR;
      S_ST_MDR:   state_next = S_WRITE;
      S_WRITE:    state_next = READY ? S_FETCH : S_WRITE;
`ifdef LC3_TRAP_EN
      S_TRAP:     state_next = S_TRAP_RD;
      S_TRAP_RD:  state_next = READY ? S_TRAP_PC : S_TRAP_RD;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  // Moore outputs; anything not set for a state stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.gate_pc   = 1'b1;
        ctrl.ld_mar    = 1'b1;
        ctrl.ld_pc     = 1'b1;
        ctrl.pcmux_sel = PCMUX_INC;
      end
      S_FETCH_RD, S_LD_RD, S_LDI_RD, S_STI_RD: begin
        ctrl.cs     = 1'b1;
        ctrl.ld_mdr = 1'b1;
      end
      S_FETCH_IR: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.ld_ir    = 1'b1;
      end
      S_DECODE: ctrl.ld_ben = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        ctrl.sr1_sel  = SR1_IR8_6;
        ctrl.aluk     = (state == S_ADD) ? ALU_ADD :
                        (state == S_AND) ? ALU_AND : ALU_NOT;
        ctrl.gate_alu = 1'b1;
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
        ctrl.dr_sel   = DR_IR11_9;
      end
      S_BR_TAKEN: begin
        ctrl.addr1_sel = ADDR1_PC;
        ctrl.addr2_sel = ADDR2_OFF9;
        ctrl.pcmux_sel = PCMUX_ADDER;
        ctrl.ld_pc     = 1'b1;
      end
      // JMP and JSRR both jump to the base register.
      S_JMP, S_JSRR: begin
        ctrl.sr1_sel   = SR1_IR8_6;
        ctrl.addr1_sel = ADDR1_SR1;
        ctrl.addr2_sel = ADDR2_ZERO;
        ctrl.pcmux_sel = PCMUX_ADDER;
        ctrl.ld_pc     = 1'b1;
      end
      S_JSR: begin
        ctrl.gate_pc = 1'b1;
        ctrl.dr_sel  = DR_R7;
        ctrl.ld_reg  = 1'b1;
      end
      S_JSR_OFF: begin
        ctrl.addr1_sel = ADDR1_PC;
        ctrl.addr2_sel = ADDR2_OFF11;
        ctrl.pcmux_sel = PCMUX_ADDER;
        ctrl.ld_pc     = 1'b1;
      end
      S_LEA: begin
        ctrl.addr1_sel   = ADDR1_PC;
        ctrl.addr2_sel   = ADDR2_OFF9;
        ctrl.marmux_sel  = MARMUX_ADDER;
        ctrl.gate_marmux = 1'b1;
        ctrl.dr_sel      = DR_IR11_9;
        ctrl.ld_reg      = 1'b1;
        ctrl.ld_cc       = 1'b1;
      end
      S_LD, S_LDI, S_ST, S_STI: begin
        ctrl.addr1_sel   = ADDR1_PC;
        ctrl.addr2_sel   = ADDR2_OFF9;
        ctrl.marmux_sel  = MARMUX_ADDER;
        ctrl.gate_marmux = 1'b1;
        ctrl.ld_mar      = 1'b1;
      end
      S_LDR, S_STR: begin
        ctrl.sr1_sel     = SR1_IR8_6;
        ctrl.addr1_sel   = ADDR1_SR1;
        ctrl.addr2_sel   = ADDR2_OFF6;
        ctrl.marmux_sel  = MARMUX_ADDER;
        ctrl.gate_marmux = 1'b1;
        ctrl.ld_mar      = 1'b1;
      end
      S_LD_WB: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.dr_sel   = DR_IR11_9;
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
      end
      // Indirect modes: the pointer just read becomes the address.
      S_LDI_MAR, S_STI_MAR: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.ld_mar   = 1'b1;
      end
      // The source register is passed through the ALU into MDR; the
      // memory stays disabled so MDR takes the bus, not RAM.
      S_ST_MDR: begin
        ctrl.sr1_sel  = SR1_IR11_9;
        ctrl.aluk     = ALU_PASSA;
        ctrl.gate_alu = 1'b1;
        ctrl.ld_mdr   = 1'b1;
      end
      S_WRITE: begin
        ctrl.cs = 1'b1;
        ctrl.we = 1'b1;
      end
`ifdef LC3_TRAP_EN
      S_TRAP: begin
        ctrl.marmux_sel  = MARMUX_ZEXT;
        ctrl.gate_marmux = 1'b1;
        ctrl.ld_mar      = 1'b1;
      end
      S_TRAP_RD: begin
        ctrl.gate_pc = 1'b1;
        ctrl.dr_sel  = DR_R7;
        ctrl.ld_reg  = 1'b1;
        ctrl.cs      = 1'b1;
        ctrl.ld_mdr  = 1'b1;
      end
      S_TRAP_PC: begin
        ctrl.gate_mdr  = 1'b1;
        ctrl.pcmux_sel = PCMUX_BUS;
        ctrl.ld_pc     = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

  lc3_nzp_ben #(.WIDTH(WIDTH)) u_nzp_ben (
    .clk     (CLK),
    .rst     (RESET),
    .bus     (BUS),
    .ir_cond (IR[11:9]),
    .ld_cc   (ctrl.ld_cc),
    .ld_ben  (ctrl.ld_ben),
    .n       (N),
    .z       (Z),
    .p       (P),
    .ben     (BEN)
  );

  assign LD_MAR      = ctrl.ld_mar;
  assign LD_MDR      = ctrl.ld_mdr;
  assign LD_IR       = ctrl.ld_ir;
  assign LD_PC       = ctrl.ld_pc;
  assign LD_REG      = ctrl.ld_reg;
  assign LD_BEN      = ctrl.ld_ben;
  assign LD_CC       = ctrl.ld_cc;
  assign GateMARMUX  = ctrl.gate_marmux;
  assign GateMDR     = ctrl.gate_mdr;
  assign GateALU     = ctrl.gate_alu;
  assign GatePC      = ctrl.gate_pc;
  assign MARMUXsel   = ctrl.marmux_sel;
  assign ADDR1MUXsel = ctrl.addr1_sel;
  assign ADDR2MUXsel = ctrl.addr2_sel;
  assign PCMUXsel    = ctrl.pcmux_sel;
  assign SR1MUXsel   = ctrl.sr1_sel;
  assign DRMUXsel    = ctrl.dr_sel;
  assign CS          = ctrl.cs;
  assign WE          = ctrl.we;
  assign ALUK        = ctrl.aluk;

endmodule

// File: tb/tb_lc3_fsm.sv
// tb_lc3_fsm -- scoreboard bench for lc3_fsm.
// Each instruction is expanded into its expected list of Patt states
// (including READY stalls); every cycle the expected outputs for that
// state plus the modelled N/Z/P/BEN are queued, and a monitor on the
// falling edge pops and compares against the DUT.
// Honours LC3_TRAP_EN the same way the design does.
module tb_lc3_fsm;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READY;
  logic [15:0] BUS;
  logic [15:0] IR;
  logic        N, Z, P, BEN;
  logic        LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_BEN, LD_CC;
  logic        GateMARMUX, GateMDR, GateALU, GatePC;
  logic        MARMUXsel, ADDR1MUXsel;
  logic [1:0]  ADDR2MUXsel, PCMUXsel, SR1MUXsel, DRMUXsel, ALUK;
  logic        CS, WE;

  lc3_fsm #(.WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .READY(READY), .BUS(BUS), .IR(IR),
    .N(N), .Z(Z), .P(P), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC),
    .LD_REG(LD_REG), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .GateMARMUX(GateMARMUX), .GateMDR(GateMDR), .GateALU(GateALU),
    .GatePC(GatePC), .MARMUXsel(MARMUXsel), .ADDR1MUXsel(ADDR1MUXsel),
    .ADDR2MUXsel(ADDR2MUXsel), .PCMUXsel(PCMUXsel), .SR1MUXsel(SR1MUXsel),
    .DRMUXsel(DRMUXsel), .CS(CS), .WE(WE), .ALUK(ALUK)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_ben, ld_cc;
    logic       gate_marmux, gate_mdr, gate_alu, gate_pc;
    logic       marmux, addr1;
    logic [1:0] addr2, pcmux, sr1, dr;
    logic       cs, we;
    logic [1:0] aluk;
    logic       n, z, p, ben;
  } obs_t;

  typedef struct {
    obs_t o;
    int   st;
  } exp_t;

  exp_t exp_q[$];
  int   path_st[$];
  logic path_rdy[$];
  int   check_count = 0;
  int   pass_count  = 0;
  logic m_n, m_z, m_p, m_ben;
  logic        bus_fixed_en;
  logic [15:0] bus_fixed_val;

  // Expected control outputs of each Patt state, straight from the state table.
  function automatic obs_t ctrl_for(input int st);
    obs_t o;
    o = '0;
    case (st)
      18: begin o.gate_pc = 1; o.ld_mar = 1; o.ld_pc = 1; o.pcmux = 2'b00; end
      33, 24, 25, 29: begin o.cs = 1; o.ld_mdr = 1; end
      35: begin o.gate_mdr = 1; o.ld_ir = 1; end
      32: o.ld_ben = 1;
      1, 5, 9: begin
        o.sr1 = 2'b01; o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; o.dr = 2'b00;
        o.aluk = (st == 1) ? 2'b00 : (st == 5) ? 2'b01 : 2'b10;
      end
      0: o = '0;
      22: begin o.addr2 = 2'b10; o.pcmux = 2'b10; o.ld_pc = 1; end
      12, 20: begin
        o.sr1 = 2'b01; o.addr1 = 1; o.addr2 = 2'b00; o.pcmux = 2'b10; o.ld_pc = 1;
      end
      4: begin o.gate_pc = 1; o.dr = 2'b01; o.ld_reg = 1; end
      21: begin o.addr2 = 2'b11; o.pcmux = 2'b10; o.ld_pc = 1; end
      14: begin
        o.addr2 = 2'b10; o.marmux = 1; o.gate_marmux = 1; o.ld_reg = 1; o.ld_cc = 1;
      end
      2, 3, 10, 11: begin o.addr2 = 2'b10; o.marmux = 1; o.gate_marmux = 1; o.ld_mar = 1; end
      6, 7: begin
        o.sr1 = 2'b01; o.addr1 = 1; o.addr2 = 2'b01; o.marmux = 1;
        o.gate_marmux = 1; o.ld_mar = 1;
      end
      27: begin o.gate_mdr = 1; o.ld_reg = 1; o.ld_cc = 1; end
      26, 31: begin o.gate_mdr = 1; o.ld_mar = 1; end
      23: begin o.aluk = 2'b11; o.gate_alu = 1; o.ld_mdr = 1; o.sr1 = 2'b00; end
      16: begin o.cs = 1; o.we = 1; end
      15: begin o.marmux = 0; o.gate_marmux = 1; o.ld_mar = 1; end
      28: begin o.gate_pc = 1; o.dr = 2'b01; o.ld_reg = 1; o.cs = 1; o.ld_mdr = 1; end
      30: begin o.gate_mdr = 1; o.pcmux = 2'b01; o.ld_pc = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [15:0] rand_bus();
    if ($urandom_range(0, 3) == 0) return 16'h0000;
    return 16'($urandom);
  endfunction

  function automatic void push_expect(input int st);
    exp_t x;
    x.o     = ctrl_for(st);
    x.o.n   = m_n;
    x.o.z   = m_z;
    x.o.p   = m_p;
    x.o.ben = m_ben;
    x.st    = st;
    exp_q.push_back(x);
  endfunction

  // Non-memory states ignore READY, so it is randomised there.
  function automatic void add_step(input int st);
    path_st.push_back(st);
    path_rdy.push_back(1'($urandom_range(0, 1)));
  endfunction

  function automatic void add_mem(input int st, input int waits);
    for (int i = 0; i < waits; i++) begin
      path_st.push_back(st);
      path_rdy.push_back(1'b0);
    end
    path_st.push_back(st);
    path_rdy.push_back(1'b1);
  endfunction

  task automatic do_step(input int st, input logic rdy);
    obs_t c;
    READY = rdy;
    BUS   = bus_fixed_en ? bus_fixed_val : rand_bus();
    push_expect(st);
    @(posedge CLK); #1;
    c = ctrl_for(st);
    if (c.ld_ben) m_ben = (IR[11] & m_n) | (IR[10] & m_z) | (IR[9] & m_p);
    if (c.ld_cc) begin
      m_n = BUS[15];
      m_z = (BUS == 16'h0000);
      m_p = !m_n && !m_z;
    end
  endtask

  // Runs one instruction from fetch back to the next fetch.
  task automatic applyStimulus(input logic [15:0] ir, input bit fix_bus,
                               input logic [15:0] bus_val, input int fetch_wait,
                               input int max_wait);
    logic       ben_new;
    logic [3:0] op;
    path_st.delete();
    path_rdy.delete();
    IR            = ir;
    bus_fixed_en  = fix_bus;
    bus_fixed_val = bus_val;
    op      = ir[15:12];
    ben_new = (ir[11] & m_n) | (ir[10] & m_z) | (ir[9] & m_p);
    add_step(18);
    add_mem(33, (fetch_wait >= 0) ? fetch_wait : $urandom_range(0, max_wait));
    add_step(35);
    add_step(32);
    case (op)
      4'b0000: begin add_step(0); if (ben_new) add_step(22); end
      4'b0001: add_step(1);
      4'b0101: add_step(5);
      4'b1001: add_step(9);
      4'b1100: add_step(12);
      4'b0100: begin add_step(4); add_step(ir[11] ? 21 : 20); end
      4'b1110: add_step(14);
      4'b0010, 4'b0110: begin
        add_step(op == 4'b0010 ? 2 : 6);
        add_mem(25, $urandom_range(0, max_wait));
        add_step(27);
      end
      4'b1010: begin
        add_step(10);
        add_mem(24, $urandom_range(0, max_wait));
        add_step(26);
        add_mem(25, $urandom_range(0, max_wait));
        add_step(27);
      end
      4'b0011, 4'b0111: begin
        add_step(op == 4'b0011 ? 3 : 7);
        add_step(23);
        add_mem(16, $urandom_range(0, max_wait));
      end
      4'b1011: begin
        add_step(11);
        add_mem(29, $urandom_range(0, max_wait));
        add_step(31);
        add_step(23);
        add_mem(16, $urandom_range(0, max_wait));
      end
`ifdef LC3_TRAP_EN
      4'b1111: begin
        add_step(15);
        add_mem(28, $urandom_range(0, max_wait));
        add_step(30);
      end
`endif
      default: ;
    endcase
    for (int i = 0; i < path_st.size(); i++) begin
      do_step(path_st[i], path_rdy[i]);
    end
  endtask

  // Enters the fetch read, stalls it, then resets in the middle of a cycle.
  task automatic resetMidAccess();
    IR           = 16'h1000;
    bus_fixed_en = 1'b0;
    do_step(18, 1'b1);
    do_step(33, 1'b0);
    RESET = 1'b1;
    READY = 1'b0;
    m_n = 1'b0; m_z = 1'b1; m_p = 1'b0; m_ben = 1'b0;
    push_expect(18);
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: one expected response per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t x;
      obs_t a;
      x = exp_q.pop_front();
      a = '{ld_mar: LD_MAR, ld_mdr: LD_MDR, ld_ir: LD_IR, ld_pc: LD_PC,
            ld_reg: LD_REG, ld_ben: LD_BEN, ld_cc: LD_CC,
            gate_marmux: GateMARMUX, gate_mdr: GateMDR, gate_alu: GateALU,
            gate_pc: GatePC, marmux: MARMUXsel, addr1: ADDR1MUXsel,
            addr2: ADDR2MUXsel, pcmux: PCMUXsel, sr1: SR1MUXsel, dr: DRMUXsel,
            cs: CS, we: WE, aluk: ALUK, n: N, z: Z, p: P, ben: BEN};
      checkOutput($sformatf("outputs_state%0d_t%0t", x.st, $time), a, x.o);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET = 1'b1; READY = 1'b1; BUS = 16'h0; IR = 16'h0;
    bus_fixed_en = 1'b0; bus_fixed_val = 16'h0;
    m_n = 1'b0; m_z = 1'b1; m_p = 1'b0; m_ben = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    push_expect(18);
    @(posedge CLK); #1;
    RESET = 1'b0;

    applyStimulus(16'h1000, 1, 16'h8000, 0, 0);
    applyStimulus(16'h5000, 1, 16'h0000, 0, 0);
    applyStimulus(16'h9000, 1, 16'h0005, 0, 0);
    applyStimulus(16'h0A05, 0, 16'h0000, 0, 0);
    applyStimulus(16'h3005, 0, 16'h0000, 0, 0);
    applyStimulus(16'hF025, 0, 16'h0000, 0, 0);
    applyStimulus(16'h8000, 0, 16'h0000, 0, 0);
    applyStimulus(16'hD000, 0, 16'h0000, 0, 0);
    applyStimulus(16'h1000, 0, 16'h0000, 3, 0);
    applyStimulus(16'h1000, 1, 16'h0005, -1, 2);
    applyStimulus(16'h0A05, 0, 16'h0000, -1, 2);
    resetMidAccess();
    repeat (200) applyStimulus(16'($urandom), 0, 16'h0000, -1, 2);

    repeat (2) @(negedge CLK);
    check_count++;
    if (exp_q.size() == 0) pass_count++;
    else $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
